// File: rtl/dma_arb_pkg.sv
// Shared types and widths for the PDP-8 memory-port DMA arbiter.
package dma_arb_types;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 12;

    typedef enum logic [1:0] {IDLE, HOLD, GRANT, RELEASE} arb_state_t;

    typedef logic [ADDR_W-1:0] maddr_t;
    typedef logic [DATA_W-1:0] mword_t;

    // Round-robin pointer width; a single master still gets a 1-bit pointer.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dma_arb_rr_pick.sv
// Round-robin priority encoder: first requester at or after ptr, wrapping.
module rr_pick #(
    parameter int NREQ  = 2,
    parameter int PTR_W = 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic             any,
    output logic [PTR_W-1:0] idx
);

    logic found;

    // Scan NREQ positions starting at ptr; the first hit wins.
    always_comb begin
        any   = |req;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[(int'(ptr) + k) % NREQ]) begin
                found = 1'b1;
                idx   = PTR_W'((int'(ptr) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/dma_arb.sv
// Cycle-stealing DMA arbiter for the PDP-8 memory port. Parks the CPU via
// cpuHOLD/cpuACK, grants one master round-robin, caps each grant at
// MAXBURST transfers and muxes the granted master onto the memory port.
module dma_arb
    import dma_arb_types::*;
#(
    parameter int NREQ     = 2,
    parameter int MAXBURST = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic [NREQ-1:0]        dmaREQ,
    output logic [NREQ-1:0]        dmaGNT,
    input  logic [NREQ*ADDR_W-1:0] dmaADDR,
    input  logic [NREQ-1:0]        dmaRD,
    input  logic [NREQ-1:0]        dmaWR,
    input  logic [NREQ*DATA_W-1:0] dmaDOUT,
    output mword_t                 dmaDIN,
    output maddr_t                 memADDR,
    output logic                   memRD,
    output logic                   memWR,
    output mword_t                 memDOUT,
    input  mword_t                 memDIN,
    output logic                   cpuHOLD,
    input  logic                   cpuACK,
    output logic                   protERR
);

    localparam int PTR_W = ptr_width(NREQ);
    localparam int CNT_W = $clog2(MAXBURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAXBURST);

    arb_state_t       state, state_nx;
    logic [PTR_W-1:0] win_q, ptr_q, ptr_nx;
    logic [CNT_W-1:0] cnt_q, cnt_nx;

    logic             pick_any;
    logic [PTR_W-1:0] pick_idx;

    logic             in_grant, sel_req, sel_rd, sel_wr, xfer, burst_done;
    maddr_t           sel_addr;
    mword_t           sel_dout;

    rr_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick (
        .req (dmaREQ),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Winner's request and strobes; only meaningful once win_q is latched.
    assign sel_req  = dmaREQ[win_q];
    assign sel_rd   = dmaRD[win_q];
    assign sel_wr   = dmaWR[win_q];
    assign sel_addr = dmaADDR[int'(win_q)*ADDR_W +: ADDR_W];
    assign sel_dout = dmaDOUT[int'(win_q)*DATA_W +: DATA_W];

    // Memory port: only the granted master reaches memory; rd+wr together is
    // a protocol error that suppresses both strobes.
    assign in_grant = (state == GRANT);
    assign memRD    = in_grant & sel_rd & ~sel_wr;
    assign memWR    = in_grant & sel_wr & ~sel_rd;
    assign protERR  = in_grant & sel_rd & sel_wr;
    assign memADDR  = in_grant ? sel_addr : '0;
    assign memDOUT  = in_grant ? sel_dout : '0;
    assign dmaDIN   = memDIN;
    assign cpuHOLD  = (state == HOLD) || (state == GRANT);
    assign dmaGNT   = in_grant ? (NREQ'(1) << win_q) : '0;

    // The transfer happening this cycle counts toward the cap, so the cycle
    // that performs transfer MAXBURST is also the last grant cycle.
    assign xfer       = memRD | memWR;
    assign cnt_nx     = (xfer && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;
    assign burst_done = (cnt_nx == CNT_MAX);
    assign ptr_nx     = (int'(win_q) + 1 >= NREQ) ? '0 : win_q + 1'b1;

    // Next-state logic for the hold/grant handshake.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pick_any) state_nx = HOLD;
            HOLD:    if (!sel_req) state_nx = RELEASE;
                     else if (cpuACK) state_nx = GRANT;
            GRANT:   if (!sel_req || burst_done) state_nx = RELEASE;
            RELEASE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register; IOCLR behaves like reset but on the clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      state <= IDLE;
        else if (clear) state <= IDLE;
        else            state <= state_nx;
    end

    // Winner latch, burst counter and round-robin pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_q <= '0;
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (clear) begin
            win_q <= '0;
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            if (state == IDLE && pick_any) win_q <= pick_idx;
            if (state == GRANT) cnt_q <= cnt_nx;
            if (state == RELEASE) begin
                cnt_q <= '0;
                ptr_q <= ptr_nx;
            end
        end
    end

endmodule

// File: tb/tb_dma_arb.sv
// Randomized and directed bench for dma_arb: two instances (MAXBURST 4 and 16)
// share all inputs and are both compared every cycle to a behavioural model.
module tb_dma_arb;

    localparam int NR = 2;

    logic          clk = 1'b0;
    logic          reset, clear, ack;
    logic [1:0]    req, rd, wr;
    logic [29:0]   addr;
    logic [23:0]   dout;
    logic [11:0]   memdin;

    logic [1:0]    a_gnt, b_gnt;
    logic [11:0]   a_din, b_din, a_dout, b_dout;
    logic [14:0]   a_addr, b_addr;
    logic          a_rd, a_wr, a_hold, a_perr, b_rd, b_wr, b_hold, b_perr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dma_arb #(.NREQ(2), .MAXBURST(4)) u_a (
        .clk(clk), .reset(reset), .clear(clear), .dmaREQ(req), .dmaGNT(a_gnt),
        .dmaADDR(addr), .dmaRD(rd), .dmaWR(wr), .dmaDOUT(dout), .dmaDIN(a_din),
        .memADDR(a_addr), .memRD(a_rd), .memWR(a_wr), .memDOUT(a_dout),
        .memDIN(memdin), .cpuHOLD(a_hold), .cpuACK(ack), .protERR(a_perr));

    dma_arb #(.NREQ(2), .MAXBURST(16)) u_b (
        .clk(clk), .reset(reset), .clear(clear), .dmaREQ(req), .dmaGNT(b_gnt),
        .dmaADDR(addr), .dmaRD(rd), .dmaWR(wr), .dmaDOUT(dout), .dmaDIN(b_din),
        .memADDR(b_addr), .memRD(b_rd), .memWR(b_wr), .memDOUT(b_dout),
        .memDIN(memdin), .cpuHOLD(b_hold), .cpuACK(ack), .protERR(b_perr));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 waiting, 1 asking CPU, 2 granted, 3 one-cycle release
    typedef struct {
        int ph;
        int win;
        int ptr;
        int cnt;
    } mdl_t;

    typedef struct packed {
        logic [1:0]  gnt;
        logic        hold, rd, wr, perr;
        logic [14:0] addr;
        logic [11:0] dout, din;
    } obs_t;

    mdl_t ma = '{0, 0, 0, 0};
    mdl_t mb = '{0, 0, 0, 0};

    function automatic obs_t predict(input mdl_t m);
        obs_t o;
        o      = '0;
        o.hold = (m.ph == 1) || (m.ph == 2);
        o.din  = memdin;
        if (m.ph == 2) begin
            o.gnt  = 2'(1 << m.win);
            o.rd   = rd[m.win] && !wr[m.win];
            o.wr   = wr[m.win] && !rd[m.win];
            o.perr = rd[m.win] && wr[m.win];
            o.addr = addr[m.win*15 +: 15];
            o.dout = dout[m.win*12 +: 12];
        end
        return o;
    endfunction

    function automatic mdl_t advance(input mdl_t m, input int cap);
        mdl_t n;
        obs_t o;
        bit   found;
        n = m;
        o = predict(m);
        found = 0;
        case (m.ph)
            0: if (req != 0) begin
                for (int k = 0; k < NR; k++)
                    if (!found && req[(m.ptr + k) % NR]) begin
                        found = 1;
                        n.win = (m.ptr + k) % NR;
                    end
                n.ph = 1;
            end
            1: if (!req[m.win]) n.ph = 3; else if (ack) n.ph = 2;
            2: begin
                if (o.rd || o.wr) n.cnt = (m.cnt < cap) ? m.cnt + 1 : cap;
                if (!req[m.win] || n.cnt >= cap) n.ph = 3;
            end
            default: begin
                n.ph  = 0;
                n.ptr = (m.win + 1) % NR;
                n.cnt = 0;
            end
        endcase
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset || clear) begin
            ma <= '{0, 0, 0, 0};
            mb <= '{0, 0, 0, 0};
        end else begin
            ma <= advance(ma, 4);
            mb <= advance(mb, 16);
        end
    end

    task automatic cmp_obs(input string who, input obs_t got, input obs_t exp);
        chk({who, ".gnt"},  32'(got.gnt),  32'(exp.gnt));
        chk({who, ".hold"}, 32'(got.hold), 32'(exp.hold));
        chk({who, ".rd"},   32'(got.rd),   32'(exp.rd));
        chk({who, ".wr"},   32'(got.wr),   32'(exp.wr));
        chk({who, ".perr"}, 32'(got.perr), 32'(exp.perr));
        chk({who, ".addr"}, 32'(got.addr), 32'(exp.addr));
        chk({who, ".dout"}, 32'(got.dout), 32'(exp.dout));
        chk({who, ".din"},  32'(got.din),  32'(exp.din));
    endtask

    // Every cycle, away from the active edge, both instances against the model.
    always @(negedge clk) begin
        cmp_obs("a", {a_gnt, a_hold, a_rd, a_wr, a_perr, a_addr, a_dout, a_din}, predict(ma));
        cmp_obs("b", {b_gnt, b_hold, b_rd, b_wr, b_perr, b_addr, b_dout, b_din}, predict(mb));
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
        memdin = 12'($urandom);
    endtask

    // Returns at +3 in a cycle where instance b grants, or flags a timeout.
    task automatic wait_b_gnt(input string tag);
        int n;
        n = 0;
        #2;
        while (b_gnt == 0 && n < 50) begin
            cyc();
            #2;
            n++;
        end
        chk({tag, "_gnt_timeout"}, 32'(n < 50), 32'd1);
    endtask

    task automatic idle_all(input int n);
        req = 0; rd = 0; wr = 0;
        repeat (n) cyc();
    endtask

    int   owners[$], low_q[$], burst_q[$];
    int   lowrun, xfers, total, first;
    logic [1:0] prev_g;
    logic prev_h;
    bit   done;

    initial begin
        reset = 1; clear = 0; ack = 0; req = 0; rd = 0; wr = 0;
        addr = 0; dout = 0; memdin = 0;
        #2;
        chk("rst_gnt", 32'(b_gnt), 0);
        chk("rst_hold", 32'(b_hold), 0);
        chk("rst_addr", 32'(b_addr), 0);
        repeat (2) cyc();
        reset = 0;
        cyc();

        // Single master, burst of three reads from 0o100.
        req = 2'b01; rd = 2'b01;
        cyc();
        #2;
        chk("s1_hold", 32'(b_hold), 1);
        chk("s1_nognt", 32'(b_gnt), 0);
        ack = 1;
        cyc();
        for (int k = 0; k < 3; k++) begin
            #2;
            addr[14:0] = 15'(15'o100 + k);
            #1;
            chk("s1_gnt", 32'(b_gnt), 1);
            chk("s1_addr", 32'(b_addr), 32'(15'o100 + k));
            chk("s1_din", 32'(b_din), 32'(memdin));
            cyc();
        end
        req = 0; rd = 0;
        cyc();
        #2;
        chk("s1_drop_gnt", 32'(b_gnt), 0);
        chk("s1_drop_hold", 32'(b_hold), 0);
        cyc();

        // Round robin on the MAXBURST=4 instance with both masters requesting.
        req = 2'b11; rd = 2'b11; ack = 1;
        lowrun = 0; xfers = 0; prev_g = 0; prev_h = 0;
        for (int i = 0; i < 40; i++) begin
            #2;
            if (a_hold && !prev_h) low_q.push_back(lowrun);
            if (a_gnt != 0 && prev_g == 0) begin
                owners.push_back(a_gnt == 2'b10 ? 1 : 0);
                xfers = 0;
            end
            if (a_gnt == 0 && prev_g != 0) burst_q.push_back(xfers);
            if (a_rd || a_wr) xfers++;
            lowrun = a_hold ? 0 : lowrun + 1;
            prev_g = a_gnt; prev_h = a_hold;
            cyc();
        end
        chk("s2_ngrants", 32'(owners.size() >= 5), 1);
        foreach (owners[i]) chk("s2_owner", 32'(owners[i]), 32'((i + 1) % 2));
        foreach (burst_q[i]) chk("s2_burst", 32'(burst_q[i]), 4);
        for (int i = 1; i < low_q.size(); i++) chk("s2_cpu_window", 32'(low_q[i]), 2);
        idle_all(4);

        // Forced release on the MAXBURST=16 instance: 20 writes from master 0.
        req = 2'b01; wr = 2'b01; ack = 1;
        total = 0; first = -1; prev_g = 0; done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            #2;
            if (b_wr) total++;
            if (b_gnt == 0 && prev_g != 0 && first < 0) first = total;
            prev_g = b_gnt;
            if (total == 20) done = 1;
            cyc();
        end
        chk("s3_done", 32'(done), 1);
        req = 0; wr = 0;
        for (int i = 0; i < 5; i++) begin
            #2;
            if (b_wr) total++;
            cyc();
        end
        chk("s3_first_burst", 32'(first), 16);
        chk("s3_total", 32'(total), 20);
        idle_all(3);

        // Protocol error: rd and wr together during a grant.
        req = 2'b01; ack = 1;
        cyc();
        wait_b_gnt("s4");
        rd = 2'b01; wr = 2'b01;
        #1;
        chk("s4_perr", 32'(b_perr), 1);
        chk("s4_rd", 32'(b_rd), 0);
        chk("s4_wr", 32'(b_wr), 0);
        cyc();
        wr = 0;
        #2;
        chk("s4_perr_once", 32'(b_perr), 0);
        chk("s4_rd_ok", 32'(b_rd), 1);
        idle_all(3);

        // clear mid-burst of master 1; restart must go through HOLD from ptr 0.
        req = 2'b11; rd = 2'b11; ack = 1;
        cyc();
        wait_b_gnt("s5");
        chk("s5_first_owner", 32'(b_gnt), 32'b10);
        total = 0;
        for (int i = 0; i < 20 && total < 5; i++) begin
            if (b_rd) total++;
            if (total < 5) begin
                cyc();
                #2;
            end
        end
        cyc();
        clear = 1;
        cyc();
        clear = 0;
        #2;
        chk("s5_clr_gnt", 32'(b_gnt), 0);
        chk("s5_clr_hold", 32'(b_hold), 0);
        cyc();
        #2;
        chk("s5_rehold", 32'(b_hold), 1);
        cyc();
        #2;
        chk("s5_regrant_ptr0", 32'(b_gnt), 32'b01);
        idle_all(3);

        // Asynchronous reset in the middle of a grant cycle.
        req = 2'b01; rd = 2'b01; addr[14:0] = 15'h1abc; ack = 1;
        cyc();
        wait_b_gnt("s6");
        reset = 1;
        #1;
        chk("s6_gnt", 32'(b_gnt), 0);
        chk("s6_hold", 32'(b_hold), 0);
        chk("s6_rd", 32'(b_rd), 0);
        chk("s6_addr", 32'(b_addr), 0);
        cyc();
        reset = 0;
        idle_all(3);

        // Request withdrawn while waiting for cpuACK: no grant, via RELEASE.
        ack = 0; req = 2'b01;
        cyc();
        req = 0;
        #2;
        chk("s7_hold", 32'(b_hold), 1);
        cyc();
        ack = 1;
        #2;
        chk("s7_rel_hold", 32'(b_hold), 0);
        chk("s7_rel_gnt", 32'(b_gnt), 0);
        cyc();
        #2;
        chk("s7_idle_gnt", 32'(b_gnt), 0);
        cyc();

        // Random traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 1500; i++) begin
            for (int m = 0; m < 2; m++) begin
                int r;
                if ($urandom_range(7) == 0) req[m] = ~req[m];
                r = $urandom_range(7);
                rd[m] = (r <= 2) || (r == 5);
                wr[m] = (r == 3) || (r == 4) || (r == 5);
            end
            ack   = ($urandom_range(3) != 0);
            addr  = 30'($urandom);
            dout  = 24'($urandom);
            clear = ($urandom_range(149) == 0);
            cyc();
        end
        clear = 0;
        idle_all(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
        $finish;
    end

endmodule
